// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared fetch-stage types and constants.
// Holds the BranchCtrl encodings, the bubble encoding, the fetch FSM state enum and the IF/ID record.
package if_stage_pkg;
  localparam logic [1:0] PC4 = 2'b00;
  localparam logic [1:0] PCIMM = 2'b01;
  localparam logic [1:0] IMMRS1 = 2'b10;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  typedef enum logic [1:0] {IDLE, WAIT, DROP} fetch_state_e;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
  } ifid_t;
endpackage

// File: rtl/if_stage_next_pc_sel.sv
// next_pc_sel: next-PC target mux.
// Ports: branch_ctrl selects seq_pc (PC4 or 11), pc_imm_target (PCIMM) or imm_rs1_target with bit0 cleared (IMMRS1); next_pc is the result.
module next_pc_sel
  import if_stage_pkg::*;
(
  input  logic [1:0]  branch_ctrl,
  input  logic [31:0] seq_pc,
  input  logic [31:0] pc_imm_target,
  input  logic [31:0] imm_rs1_target,
  output logic [31:0] next_pc
);
  always_comb
    next_pc = branch_ctrl == PCIMM  ? pc_imm_target :
              branch_ctrl == IMMRS1 ? (imm_rs1_target & ~32'd1) : seq_pc;
endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch with PC, one-outstanding-request memory handshake, 1-entry skid buffer and IF/ID register.
// Ports: clk/rst_n (async active-low); PC_write, IFID_RegWrite (0 = stall), instrFlush, BranchCtrl + targets from ID/hazard unit;
//        im_req/im_addr/im_rvalid/im_rdata to instruction memory; IFID_pc/IFID_instr/IFID_valid to ID; fetch_stall.
// Optional: IF_STAGE_PERF_EN adds perf_fetched (accepted words) and perf_bubbles (fetch_stall cycles), both saturating.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PC_write,
  input  logic        IFID_RegWrite,
  input  logic        instrFlush,
  input  logic [1:0]  BranchCtrl,
  input  logic [31:0] pc_imm_target,
  input  logic [31:0] imm_rs1_target,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_rvalid,
  input  logic [31:0] im_rdata,
  output logic [31:0] IFID_pc,
  output logic [31:0] IFID_instr,
  output logic        IFID_valid,
  output logic        fetch_stall
`ifdef IF_STAGE_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubbles
`endif
);
  import if_stage_pkg::*;

  localparam ifid_t BUBBLE = '{pc: 32'd0, instr: NOP_INSTR, valid: 1'b0};

  fetch_state_e state_q, state_d;
  logic [31:0] pc_q, pc_d, req_addr_q, req_addr_d, seq_pc, target;
  ifid_t ifid_q, ifid_d, skid_q, skid_d, resp;
  logic stall, pending, accept, skid_after, issue;

  assign stall = !PC_write || !IFID_RegWrite;
  // A request is still open until its response shows up; a response cycle may start a new request.
  assign pending = state_q != IDLE && !im_rvalid;
  assign accept = state_q == WAIT && im_rvalid && !instrFlush;
  assign seq_pc = accept ? req_addr_q + 32'd4 : pc_q;
  assign resp = '{pc: req_addr_q, instr: im_rdata, valid: 1'b1};
  // Skid entry survives this cycle only while ID is stalled; no fetch may start while it is occupied.
  assign skid_after = (skid_q.valid || accept) && stall;
  assign issue = rst_n && !instrFlush && !skid_after && (state_q == IDLE || accept);

  next_pc_sel u_next_pc_sel (
    .branch_ctrl   (BranchCtrl),
    .seq_pc        (seq_pc),
    .pc_imm_target (pc_imm_target),
    .imm_rs1_target(imm_rs1_target),
    .next_pc       (target)
  );

  always_comb begin
    im_req = rst_n && (pending || issue);
    im_addr = pending ? req_addr_q : seq_pc;
    fetch_stall = rst_n && !instrFlush && !stall && !skid_q.valid && !accept;
    state_d = issue ? WAIT : pending ? (instrFlush ? DROP : state_q) : IDLE;
    req_addr_d = issue ? seq_pc : req_addr_q;
    pc_d = instrFlush ? target : seq_pc;
    skid_d = skid_q;
    if (instrFlush || !stall) skid_d.valid = 1'b0;
    else if (accept) skid_d = resp;
    ifid_d = instrFlush ? BUBBLE : stall ? ifid_q : skid_q.valid ? skid_q : accept ? resp : BUBBLE;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      ifid_q <= BUBBLE;
      skid_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      req_addr_q <= req_addr_d;
      ifid_q <= ifid_d;
      skid_q <= skid_d;
    end

  assign IFID_pc = ifid_q.pc;
  assign IFID_instr = ifid_q.instr;
  assign IFID_valid = ifid_q.valid;

`ifdef IF_STAGE_PERF_EN
  logic [31:0] fetched_q, fetched_d, bubbles_q, bubbles_d;

  always_comb begin
    fetched_d = fetched_q + 32'(accept && !(&fetched_q));
    bubbles_d = bubbles_q + 32'(fetch_stall && !(&bubbles_q));
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fetched_q <= '0;
      bubbles_q <= '0;
    end else begin
      fetched_q <= fetched_d;
      bubbles_q <= bubbles_d;
    end

  assign perf_fetched = fetched_q;
  assign perf_bubbles = bubbles_q;
`endif
endmodule
